// File: rtl/music_pkg.sv
// music_pkg: shared states and ROM word field layout for the music sequencer
package music_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, PLAY, GAP, NEXT} state_t;
  localparam int DUR_MSB = 15;
  localparam int DUR_LSB = 8;
  localparam int NOTE_MSB = 7;
  localparam int NOTE_LSB = 0;
  localparam logic [7:0] END_MARKER = 8'd0;
  localparam logic [7:0] REST_CODE = 8'd0;
endpackage

// File: rtl/music_sequencer_if.sv
// music_sequencer_if: control, ROM and tone-generator signals of the sequencer
interface music_sequencer_if #(parameter int ADDR_W = 7, parameter int DATA_W = 16);
  logic start;
  logic stop;
  logic loop_en;
  logic [ADDR_W-1:0] rom_addr;
  logic rom_rd_en;
  logic [DATA_W-1:0] rom_data;
  logic [7:0] note_code;
  logic note_on;
  logic busy;
  logic done;
  modport master(input start, stop, loop_en, rom_data,
                 output rom_addr, rom_rd_en, note_code, note_on, busy, done);
  modport slave(output start, stop, loop_en, rom_data,
                input rom_addr, rom_rd_en, note_code, note_on, busy, done);
endinterface

// File: rtl/music_sequencer_beat_timer.sv
// beat_timer: loadable down-counter with terminal-count flag for note and gap timing
module beat_timer #(parameter int W = 10) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic [W-1:0] load_val,
  output logic tc
);
  logic [W-1:0] cnt;
  // load takes priority; otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - W'(1);
  end
  assign tc = cnt == '0;
endmodule

// File: rtl/music_sequencer.sv
// music_sequencer: steps the song ROM and plays each note for its encoded beat count
module music_sequencer
  import music_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16,
  parameter int TICK_CYCLES = 6_750_000,
  parameter int GAP_CYCLES = 270_000
) (
  input logic sys_clk,
  input logic sys_rst,
  music_sequencer_if.master bus
);
  localparam int PW = 8 + $clog2(TICK_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int CW = PW > GW ? PW : GW;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0] code_n, dur, note;
  logic on_n, done_n, ld, tc, eos;
  logic [CW-1:0] ld_val;
  assign dur = bus.rom_data[DUR_MSB:DUR_LSB];
  assign note = bus.rom_data[NOTE_MSB:NOTE_LSB];
  assign eos = (state == LATCH && dur == END_MARKER) || (state == NEXT && &bus.rom_addr);
  assign bus.rom_rd_en = state == FETCH;
  assign bus.busy = state != IDLE;
  beat_timer #(.W(CW)) u_timer (
    .clk(sys_clk),
    .rst(sys_rst),
    .load(ld),
    .load_val(ld_val),
    .tc(tc)
  );
  // state and output registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      bus.rom_addr <= '0;
      bus.note_code <= REST_CODE;
      bus.note_on <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state <= state_n;
      bus.rom_addr <= addr_n;
      bus.note_code <= code_n;
      bus.note_on <= on_n;
      bus.done <= done_n;
    end
  end
  // next state, timer loads and end-of-song / stop handling
  always_comb begin
    state_n = state;
    addr_n = bus.rom_addr;
    code_n = bus.note_code;
    on_n = bus.note_on;
    done_n = 1'b0;
    ld = 1'b0;
    ld_val = '0;
    case (state)
      IDLE: if (bus.start && !bus.stop) begin
        state_n = FETCH;
        addr_n = '0;
      end
      FETCH: state_n = LATCH;
      LATCH: if (!eos) begin
        code_n = note;
        on_n = note != REST_CODE;
        ld = 1'b1;
        ld_val = CW'(dur) * CW'(TICK_CYCLES) - CW'(1);
        state_n = PLAY;
      end
      PLAY: if (tc) begin
        code_n = REST_CODE;
        on_n = 1'b0;
        if (GAP_CYCLES == 0) state_n = NEXT;
        else begin
          ld = 1'b1;
          ld_val = CW'(GAP_CYCLES - 1);
          state_n = GAP;
        end
      end
      GAP: if (tc) state_n = NEXT;
      NEXT: if (!eos) begin
        addr_n = bus.rom_addr + ADDR_W'(1);
        state_n = FETCH;
      end
      default: state_n = IDLE;
    endcase
    if (eos && bus.loop_en && bus.rom_addr != '0) begin
      addr_n = '0;
      state_n = FETCH;
    end else if (eos) begin
      done_n = 1'b1;
      state_n = IDLE;
    end
    if (bus.stop && state != IDLE) begin
      state_n = IDLE;
      code_n = REST_CODE;
      on_n = 1'b0;
      done_n = 1'b0;
      ld = 1'b0;
    end
  end
endmodule

// File: tb/tb_music_sequencer.sv
// tb_music_sequencer: directed scenarios with hand-derived cycle schedules (TICK=4, GAP=2)
module tb_music_sequencer;
  logic sys_clk = 1'b0;
  logic sys_rst;
  logic [15:0] rom [128];
  int total = 0;
  int bad = 0;
  music_sequencer_if #(.ADDR_W(7), .DATA_W(16)) bus ();
  music_sequencer #(.ADDR_W(7), .DATA_W(16), .TICK_CYCLES(4), .GAP_CYCLES(2)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus)
  );
  // free-running clock
  always #5 sys_clk = ~sys_clk;
  // synchronous ROM model, one-cycle read latency
  always @(posedge sys_clk) if (bus.rom_rd_en) bus.rom_data <= rom[bus.rom_addr];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // {busy, done, rom_rd_en, note_on, note_code, rom_addr}
  function automatic logic [18:0] obs();
    return {bus.busy, bus.done, bus.rom_rd_en, bus.note_on, bus.note_code, bus.rom_addr};
  endfunction

  // schedule for ROM {0x0245, 0x0150, 0x0000}; c=0 is the FETCH cycle
  function automatic logic [18:0] basic_exp(input int c);
    logic [7:0] code;
    logic [6:0] a;
    code = (c >= 2 && c <= 9) ? 8'h45 : (c >= 15 && c <= 18) ? 8'h50 : 8'h00;
    a = c < 13 ? 7'd0 : c < 22 ? 7'd1 : 7'd2;
    return {c < 24, c == 24, c == 0 || c == 13 || c == 22, code != 8'h00, code, a};
  endfunction

  task automatic do_reset();
    sys_rst = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.loop_en = 1'b0;
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (obs() !== 19'h0) begin bad++; $display("FAIL reset got=%h want=%h", obs(), 19'h0); end
    tick();
    total++;
    if (obs() !== 19'h0) begin bad++; $display("FAIL reset_idle got=%h want=%h", obs(), 19'h0); end
  endtask

  task automatic test_basic();
    do_reset();
    rom[0] = 16'h0245;
    rom[1] = 16'h0150;
    pulse_start();
    for (int c = 0; c <= 26; c++) begin
      if (c > 0) tick();
      total++;
      if (obs() !== basic_exp(c)) begin bad++; $display("FAIL basic c=%0d got=%h want=%h", c, obs(), basic_exp(c)); end
    end
  endtask

  task automatic test_rest_latency();
    logic [18:0] e;
    do_reset();
    rom[0] = 16'h0300;
    for (int i = 0; i < 9; i++) tick();
    pulse_start();
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) tick();
      e = {c < 19, c == 19, c == 0 || c == 17, 1'b0, 8'h00, c < 17 ? 7'd0 : 7'd1};
      total++;
      if (obs() !== e) begin bad++; $display("FAIL rest c=%0d got=%h want=%h", c, obs(), e); end
    end
  endtask

  task automatic test_loop();
    logic [18:0] e;
    int p;
    do_reset();
    rom[0] = 16'h0111;
    bus.loop_en = 1'b1;
    pulse_start();
    for (int c = 0; c <= 57; c++) begin
      if (c > 0) tick();
      p = c % 11;
      e = {c < 55, c == 55, c < 55 && (p == 0 || p == 9), c < 55 && p >= 2 && p <= 5,
           (c < 55 && p >= 2 && p <= 5) ? 8'h11 : 8'h00, (c >= 54 || p == 9 || p == 10) ? 7'd1 : 7'd0};
      total++;
      if (obs() !== e) begin bad++; $display("FAIL loop c=%0d got=%h want=%h", c, obs(), e); end
      if (c == 47) bus.loop_en = 1'b0;
    end
  endtask

  task automatic test_empty();
    logic [18:0] e;
    do_reset();
    bus.loop_en = 1'b1;
    pulse_start();
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) tick();
      e = {c < 2, c == 2, c == 0, 1'b0, 8'h00, 7'd0};
      total++;
      if (obs() !== e) begin bad++; $display("FAIL empty c=%0d got=%h want=%h", c, obs(), e); end
    end
  endtask

  task automatic test_stop_start();
    logic [18:0] o;
    do_reset();
    rom[0] = 16'h0245;
    rom[1] = 16'h0150;
    pulse_start();
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) tick();
      total++;
      if (obs() !== basic_exp(c)) begin bad++; $display("FAIL start_busy c=%0d got=%h want=%h", c, obs(), basic_exp(c)); end
      bus.start = c == 3;
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    o = obs();
    total++;
    if (o[18:7] !== 12'h0) begin bad++; $display("FAIL stop got=%h want=%h", o[18:7], 12'h0); end
    tick();
    o = obs();
    total++;
    if (o[18:7] !== 12'h0) begin bad++; $display("FAIL stop_idle got=%h want=%h", o[18:7], 12'h0); end
    bus.start = 1'b1;
    bus.stop = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop = 1'b0;
    o = obs();
    total++;
    if (o[18:7] !== 12'h0) begin bad++; $display("FAIL start_stop got=%h want=%h", o[18:7], 12'h0); end
    tick();
    o = obs();
    total++;
    if (o[18:7] !== 12'h0) begin bad++; $display("FAIL start_stop_after got=%h want=%h", o[18:7], 12'h0); end
  endtask

  task automatic test_wrap();
    logic [18:0] e;
    int p;
    logic act;
    do_reset();
    for (int i = 0; i < 128; i++) rom[i] = 16'h0101;
    pulse_start();
    for (int c = 0; c <= 1154; c++) begin
      if (c > 0) tick();
      p = c % 9;
      act = c < 1152 && p >= 2 && p <= 5;
      e = {c < 1152, c == 1152, c < 1152 && p == 0, act, act ? 8'h01 : 8'h00, c < 1152 ? 7'(c / 9) : 7'd127};
      total++;
      if (obs() !== e) begin bad++; $display("FAIL wrap c=%0d got=%h want=%h", c, obs(), e); end
    end
  endtask

  task automatic test_rst_gap();
    do_reset();
    rom[0] = 16'h0245;
    rom[1] = 16'h0150;
    pulse_start();
    for (int c = 0; c <= 19; c++) begin
      if (c > 0) tick();
      total++;
      if (obs() !== basic_exp(c)) begin bad++; $display("FAIL rst_pre c=%0d got=%h want=%h", c, obs(), basic_exp(c)); end
    end
    sys_rst = 1'b1;
    tick();
    total++;
    if (obs() !== 19'h0) begin bad++; $display("FAIL rst_gap got=%h want=%h", obs(), 19'h0); end
    sys_rst = 1'b0;
    tick();
    total++;
    if (obs() !== 19'h0) begin bad++; $display("FAIL rst_after got=%h want=%h", obs(), 19'h0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rest_latency();
    test_loop();
    test_empty();
    test_stop_start();
    test_wrap();
    test_rst_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/music_sequencer.md
Name: music_sequencer

Overview:
Plays a song stored in the speaker_music note ROM (128 x 16-bit words, 1-cycle synchronous read). It steps the ROM address, decodes each word into note code and duration, and holds the note for the encoded number of beat ticks. A fixed articulation gap follows each note. Output drives the downstream tone generator (note_code/note_on); start/stop/loop come from the top-level button/UI logic.

Parameters:
ADDR_W, 7, ROM address width (song length 2^ADDR_W words)
DATA_W, 16, ROM word width
TICK_CYCLES, 6_750_000, sys_clk cycles per beat tick (1/4 s at 27 MHz); >=1
GAP_CYCLES, 270_000, silent cycles between notes; 0 = no gap

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous reset, active-high
start  in  1  level/pulse; begin playback from address 0 when idle
stop  in  1  abort playback
loop_en  in  1  restart at address 0 after end of song
rom_addr  out  ADDR_W  ROM address
rom_rd_en  out  1  ROM read enable
rom_data  in  DATA_W  ROM read data, valid cycle after rom_rd_en
note_code  out  8  current note index to tone generator; 0 = rest
note_on  out  1  tone generator enable
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at end of song (non-loop) or empty song

Behaviour:
- Interface: one clock sys_clk; reset sys_rst is synchronous and active-high.
- ROM word: [15:8] duration in ticks (0 = end-of-song marker), [7:0] note_code (0 = rest).
- Reset values: state IDLE, rom_addr 0, rom_rd_en 0, note_code 0, note_on 0, busy 0, done 0, counters 0.
- States:
  - IDLE -> FETCH on start && !stop; rom_addr <= 0.
  - FETCH: rom_rd_en=1 for exactly one cycle -> LATCH.
  - LATCH: sample rom_data.
    - dur==0: end of song.
    - Else note_code <= data[7:0], note_on <= (data[7:0]!=0) -> PLAY.
  - PLAY: duration counter loads dur*TICK_CYCLES-1 and counts down to 0. PLAY lasts exactly dur*TICK_CYCLES cycles. Then note_on <= 0, note_code <= 0 -> GAP, or -> NEXT if GAP_CYCLES==0.
  - GAP: exactly GAP_CYCLES cycles -> NEXT.
  - NEXT: 1 cycle.
    - rom_addr==2^ADDR_W-1 is end of song.
    - Otherwise rom_addr+1 -> FETCH.
- End of song:
  - loop_en=1 and rom_addr!=0: rom_addr <= 0 -> FETCH.
  - Otherwise: done pulse -> IDLE.
  - Empty song (marker at addr 0) never loops.
- Latency: start sampled at cycle N gives rom_rd_en at N+1 and note_on at N+3.
- Counter width: 8+clog2(TICK_CYCLES) bits; no overflow for dur=255.
- stop in any non-IDLE state: next cycle IDLE, note_on=0, note_code=0, rom_rd_en=0, no done pulse. stop and start together in IDLE: stay IDLE.
- start while busy: ignored; playback is not restarted.
- loop_en is sampled only at end-of-song; it may change freely mid-song.
- Address wrap at 127 without an end marker is treated as end of song.
- sys_rst mid-play: all outputs return to reset values next cycle.

Decomposition:
- Shared package music_pkg:
  - state enum (IDLE, FETCH, LATCH, PLAY, GAP, NEXT)
  - field constants DUR_MSB=15, DUR_LSB=8, NOTE_MSB=7, NOTE_LSB=0
  - END_MARKER=0, REST_CODE=0
- One sub-module: beat_timer, a loadable down-counter (load value, terminal-count flag) used for both PLAY and GAP.

Test Plan:
All scenarios use TICK_CYCLES=4, GAP_CYCLES=2.
- Basic song: ROM {0x0245, 0x0150, 0x0000}; start -> note_on with code 0x45 for 8 cycles, 2 low, then code 0x50 for 4 cycles, 2 low. done pulses once after the marker fetch; busy then drops.
- Rest and latency: ROM[0]=0x0300; start at cycle 10 -> rom_rd_en at cycle 11, note_on stays 0 for 12 PLAY cycles, timing identical to a note.
- Loop: ROM {0x0111, 0x0000}, loop_en=1 -> rom_addr sequence 0,1,0,1,... and no done. Clear loop_en mid-note -> done after the next marker.
- Empty song: ROM[0]=0x0000, loop_en=1 -> done pulse 2 cycles after FETCH, return to IDLE, no hang.
- Stop/start races: stop mid-PLAY -> note_on=0 and IDLE next cycle, no done. start during PLAY -> ignored. start+stop in IDLE -> stays IDLE.
- Wrap and reset: all 128 words dur=1, loop_en=0 -> done after addr 127. sys_rst asserted in GAP -> all outputs at reset values next cycle.
